// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with freeze/flush; priority reset > freeze > flush > load.
// Optional saturating stall/flush statistics counters are built when ID_EXE_STAT_CNT_EN is defined.
module id_exe_stage_reg #(
  parameter int DW   = 32,
  parameter int RW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,
  input  logic [DW-1:0]   pc_in,
  input  logic [DW-1:0]   val_rn_in,
  input  logic [DW-1:0]   val_rm_in,
  input  logic            imm_in,
  input  logic [11:0]     shift_operand_in,
  input  logic [23:0]     signed_imm24_in,
  input  logic [RW-1:0]   dest_in,
  input  logic [RW-1:0]   src1_in,
  input  logic [RW-1:0]   src2_in,
  input  logic [3:0]      exe_cmd_in,
  input  logic            wb_en_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            b_in,
  input  logic            s_in,
  input  logic [3:0]      sr_in,
  output logic [DW-1:0]   pc_out,
  output logic [DW-1:0]   val_rn_out,
  output logic [DW-1:0]   val_rm_out,
  output logic            imm_out,
  output logic [11:0]     shift_operand_out,
  output logic [23:0]     signed_imm24_out,
  output logic [RW-1:0]   dest_out,
  output logic [RW-1:0]   src1_id_reg,
  output logic [RW-1:0]   src2_id_reg,
  output logic [3:0]      exe_cmd_out,
  output logic            wb_en_out,
  output logic            mem_r_en_out,
  output logic            mem_w_en_out,
  output logic            b_out,
  output logic            s_out,
  output logic [3:0]      sr_out,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);
  // A bubble is all-zero, so wb_en_out=0 keeps its dest=0 from ever forwarding.
  always_ff @(posedge clk)
    if (!rst || (!freeze && flush))
      {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
       dest_out, src1_id_reg, src2_id_reg, exe_cmd_out, wb_en_out, mem_r_en_out,
       mem_w_en_out, b_out, s_out, sr_out} <= '0;
    else if (!freeze)
      {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
       dest_out, src1_id_reg, src2_id_reg, exe_cmd_out, wb_en_out, mem_r_en_out,
       mem_w_en_out, b_out, s_out, sr_out} <=
      {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
       dest_in, src1_in, src2_in, exe_cmd_in, wb_en_in, mem_r_en_in,
       mem_w_en_in, b_in, s_in, sr_in};
`ifdef ID_EXE_STAT_CNT_EN
  always_ff @(posedge clk)
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (!freeze && flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
